mac_dot_driver: RTL

//  Initiator side of the MAC accumulate interface (en/a/b/finalize -> out/out_valid).

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_dot_driver_if.sv | 36 +++
 rtl/mac_cycle_counter.sv | 39 +++
 rtl/mac_dot_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, FSM encoding and counter load values for the MAC dot-product driver.
package mac_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 64;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned DRAIN = 8;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Down-counter loads: DRAIN counts the idle gap, TMO gives 2**TMO_W-1 WAIT cycles.
  localparam logic [TMO_W-1:0] DRAIN_LOAD = TMO_W'(DRAIN);
  localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'((1 << TMO_W) - 2);

endpackage

// File: rtl/mac_dot_driver_if.sv
// Job, operand stream, MAC and result signals of the dot-product driver.
interface mac_dot_driver_if;
  import mac_pkg::*;

  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    busy;
  logic                    op_valid;
  logic                    op_ready;
  logic signed [DW-1:0]    op_a;
  logic signed [DW-1:0]    op_b;
  logic                    mac_en;
  logic signed [DW-1:0]    mac_a;
  logic signed [DW-1:0]    mac_b;
  logic                    mac_finalize;
  logic signed [AW-1:0]    mac_out;
  logic                    mac_out_valid;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [AW-1:0]    res_data;
  logic [LEN_W-1:0]        res_count;
  logic                    err_timeout;

  modport master (
    input  start, len, op_valid, op_a, op_b, mac_out, mac_out_valid, res_ready,
    output busy, op_ready, mac_en, mac_a, mac_b, mac_finalize,
           res_valid, res_data, res_count, err_timeout
  );

  modport slave (
    output start, len, op_valid, op_a, op_b, mac_out, mac_out_valid, res_ready,
    input  busy, op_ready, mac_en, mac_a, mac_b, mac_finalize,
           res_valid, res_data, res_count, err_timeout
  );

endinterface

// File: rtl/mac_cycle_counter.sv
// Loadable down-counter with zero flag; shared by the drain gap and the WAIT timeout.
module mac_cycle_counter
  import mac_pkg::*;
#(
  parameter int unsigned W = TMO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_zero_c = (count_q == '0);

endmodule

// File: rtl/mac_dot_driver.sv
// Issues a dot-product job to the MAC, drains its pipeline, finalizes and returns the result.
module mac_dot_driver
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mac_dot_driver_if.master bus
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  mac_en_q, mac_en_d;
  logic signed [DW-1:0]  mac_a_q, mac_a_d;
  logic signed [DW-1:0]  mac_b_q, mac_b_d;
  logic                  mac_fin_q, mac_fin_d;
  logic                  res_valid_q, res_valid_d;
  logic signed [AW-1:0]  res_data_q, res_data_d;
  logic [LEN_W-1:0]      res_count_q, res_count_d;
  logic                  err_q, err_d;

  logic                  op_ready_c;
  logic                  hs_c;
  logic                  ctr_load;
  logic [TMO_W-1:0]      ctr_val;
  logic                  ctr_dec;
  logic                  ctr_zero_c;

  assign op_ready_c = (state_q == ST_ISSUE) && (cnt_q < len_q);
  assign hs_c       = bus.op_valid && op_ready_c;

  mac_cycle_counter #(.W(TMO_W)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load),
    .load_val  (ctr_val),
    .dec       (ctr_dec),
    .is_zero_c (ctr_zero_c)
  );

  // Next-state and next-output logic for the job sequence.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    err_d       = err_q;
    ctr_load    = 1'b0;
    ctr_val     = DRAIN_LOAD;
    ctr_dec     = 1'b0;
    mac_en_d    = hs_c;
    mac_a_d     = hs_c ? bus.op_a : '0;
    mac_b_d     = hs_c ? bus.op_b : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          err_d = 1'b0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            cnt_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            cnt_d       = '0;
            res_data_d  = '0;
            res_count_d = '0;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_ISSUE: begin
        if (hs_c) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == (len_q - LEN_W'(1))) begin
            ctr_load = 1'b1;
            ctr_val  = DRAIN_LOAD;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (ctr_zero_c) begin
          state_d = ST_FIN;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_FIN: begin
        ctr_load = 1'b1;
        ctr_val  = TMO_LOAD;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mac_out_valid) begin
          res_data_d  = bus.mac_out;
          res_count_d = cnt_q;
          state_d     = ST_HOLD;
        end else if (ctr_zero_c) begin
          err_d       = 1'b1;
          res_data_d  = '0;
          res_count_d = cnt_q;
          state_d     = ST_HOLD;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    mac_fin_d   = (state_d == ST_FIN);
    res_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_fin_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_fin_q   <= mac_fin_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.op_ready     = op_ready_c;
  assign bus.mac_en       = mac_en_q;
  assign bus.mac_a        = mac_a_q;
  assign bus.mac_b        = mac_b_q;
  assign bus.mac_finalize = mac_fin_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_count    = res_count_q;
  assign bus.err_timeout  = err_q;

endmodule
